// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: circular trace capture of per-cycle CPU debug records.
// Captures while armed, stops a programmable number of samples after a
// trigger, then streams the captured window out oldest-first over a
// valid/ready read port.
module cpu_trace_buffer #(
   parameter  int WORD_WIDTH  = 16,
   parameter  int REC_WIDTH   = 64,
   parameter  int DEPTH       = 16,
   parameter  int STATE_WIDTH = 10,
   localparam int CW          = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   arm,
   input  logic                   abort,
   input  logic [1:0]             trig_mode,
   input  logic [WORD_WIDTH-1:0]  trig_value,
   input  logic [CW-1:0]          post_count,
   input  logic                   sample_en,
   input  logic [WORD_WIDTH-1:0]  pc,
   input  logic [STATE_WIDTH-1:0] exec_state,
   input  logic                   ext_trig,
   input  logic [REC_WIDTH-1:0]   rec_in,
   input  logic                   rd_start,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [REC_WIDTH-1:0]   rd_data,
   output logic                   rd_last,
   output logic [2:0]             state,
   output logic [CW-1:0]          fill,
   output logic                   triggered
);

   localparam int            AW      = $clog2(DEPTH);
   localparam int            IW      = (STATE_WIDTH > 1) ? $clog2(STATE_WIDTH) : 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] MAXPOST = CW'(DEPTH - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_POST    = 3'd2,
      S_DONE    = 3'd3,
      S_READOUT = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [AW-1:0]         wptr_q, wptr_d;
   logic [AW-1:0]         rptr_q, rptr_d;
   logic [CW-1:0]         fill_q, fill_d;
   logic [CW-1:0]         post_q, post_d;
   logic [CW-1:0]         postlen_q, postlen_d;
   logic [CW-1:0]         rem_q, rem_d;
   logic                  trig_q, trig_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_last_q, rd_last_d;
   logic [REC_WIDTH-1:0]  rd_data_q, rd_data_d;
   logic [REC_WIDTH-1:0]  mem_q [DEPTH];
   logic                  wr_en;
   logic                  state_hit;
   logic                  fire;

   // Trigger condition for the current cycle; indices past STATE_WIDTH never match.
   always_comb begin
      state_hit = 1'b0;
      for (int unsigned i = 0; i < STATE_WIDTH; i++) begin
         if (trig_value[IW-1:0] == IW'(i)) state_hit = exec_state[i];
      end
      case (trig_mode)
         2'd0:    fire = 1'b1;
         2'd1:    fire = (pc == trig_value);
         2'd2:    fire = state_hit;
         default: fire = ext_trig;
      endcase
   end

   // Next-state logic: abort beats arm, arm beats normal capture/readout.
   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      fill_d     = fill_q;
      post_d     = post_q;
      postlen_d  = postlen_q;
      rem_d      = rem_q;
      trig_d     = trig_q;
      rd_valid_d = rd_valid_q;
      rd_last_d  = rd_last_q;
      rd_data_d  = rd_data_q;
      wr_en      = 1'b0;

      if (abort) begin
         state_d    = S_IDLE;
         trig_d     = 1'b0;
         rd_valid_d = 1'b0;
         rd_last_d  = 1'b0;
      end else if (arm && (state_q == S_IDLE || state_q == S_DONE)) begin
         state_d   = S_ARMED;
         wptr_d    = '0;
         fill_d    = '0;
         trig_d    = 1'b0;
         postlen_d = (post_count > MAXPOST) ? MAXPOST : post_count;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (sample_en) begin
                  wr_en = 1'b1;
                  if (fire) begin
                     trig_d = 1'b1;
                     if (postlen_q == '0) begin
                        state_d = S_DONE;
                     end else begin
                        state_d = S_POST;
                        post_d  = postlen_q;
                     end
                  end
               end
            end
            S_POST: begin
               if (sample_en) begin
                  wr_en  = 1'b1;
                  post_d = post_q - ONE;
                  if (post_q == ONE) state_d = S_DONE;
               end
            end
            S_DONE: begin
               if (rd_start) begin
                  state_d = S_READOUT;
                  rptr_d  = wptr_q - fill_q[AW-1:0];
                  rem_d   = fill_q;
               end
            end
            S_READOUT: begin
               // rem_q counts records not yet presented; the first record is
               // loaded on the cycle after entry, while rd_valid is still low.
               if (!rd_valid_q || rd_ready) begin
                  if (rem_q != '0) begin
                     rd_data_d  = mem_q[rptr_q];
                     rd_valid_d = 1'b1;
                     rd_last_d  = (rem_q == ONE);
                     rptr_d     = rptr_q + 1'b1;
                     rem_d      = rem_q - ONE;
                  end else begin
                     rd_valid_d = 1'b0;
                     rd_last_d  = 1'b0;
                     state_d    = S_DONE;
                  end
               end
            end
            default: ;
         endcase

         if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
            if (fill_q != FULL) fill_d = fill_q + ONE;
         end
      end
   end

   // Control and readout registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         fill_q     <= '0;
         post_q     <= '0;
         postlen_q  <= '0;
         rem_q      <= '0;
         trig_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         fill_q     <= fill_d;
         post_q     <= post_d;
         postlen_q  <= postlen_d;
         rem_q      <= rem_d;
         trig_q     <= trig_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Trace storage; contents survive abort and reset, only pointers are cleared.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[wptr_q] <= rec_in;
   end

   assign state     = state_q;
   assign fill      = fill_q;
   assign triggered = trig_q;
   assign rd_valid  = rd_valid_q;
   assign rd_last   = rd_last_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: directed scenarios plus randomized traffic, every
// cycle compared against a queue-based behavioural model of the trace buffer.
module tb_cpu_trace_buffer;

   localparam int WW = 16;
   localparam int RW = 64;
   localparam int D  = 16;
   localparam int SW = 10;
   localparam int CW = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst, arm, abort, sample_en, ext_trig, rd_start, rd_ready;
   logic [1:0]    trig_mode;
   logic [WW-1:0] trig_value, pc;
   logic [CW-1:0] post_count;
   logic [SW-1:0] exec_state;
   logic [RW-1:0] rec_in;
   logic          rd_valid, rd_last, triggered;
   logic [RW-1:0] rd_data;
   logic [2:0]    state;
   logic [CW-1:0] fill;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   cpu_trace_buffer #(
      .WORD_WIDTH (WW),
      .REC_WIDTH  (RW),
      .DEPTH      (D),
      .STATE_WIDTH(SW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .arm       (arm),
      .abort     (abort),
      .trig_mode (trig_mode),
      .trig_value(trig_value),
      .post_count(post_count),
      .sample_en (sample_en),
      .pc        (pc),
      .exec_state(exec_state),
      .ext_trig  (ext_trig),
      .rec_in    (rec_in),
      .rd_start  (rd_start),
      .rd_ready  (rd_ready),
      .rd_valid  (rd_valid),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .state     (state),
      .fill      (fill),
      .triggered (triggered)
   );

   // Behavioural model: the buffer is the queue of the last D samples since arm.
   logic [RW-1:0] m_hist[$];
   logic [RW-1:0] m_stream[$];
   int            m_state, m_post, m_postlen, m_ridx;
   bit            m_trig, m_rdv, m_rlast;
   logic [RW-1:0] m_rdata;

   logic [RW-1:0] rd_got[$];
   bit            rd_got_last[$];
   logic [RW-1:0] saved[$];

   task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit model_fires();
      int idx;
      case (trig_mode)
         2'd0: return 1'b1;
         2'd1: return pc == trig_value;
         2'd2: begin
            idx = int'(trig_value) % (1 << $clog2(SW));
            return (idx < SW) ? exec_state[idx] : 1'b0;
         end
         default: return ext_trig;
      endcase
   endfunction

   task automatic model_store();
      m_hist.push_back(rec_in);
      if (m_hist.size() > D) void'(m_hist.pop_front());
   endtask

   task automatic model_step();
      if (rst) begin
         m_state = 0; m_hist.delete(); m_trig = 0;
         m_rdv = 0; m_rlast = 0; m_rdata = '0;
      end else if (abort) begin
         m_state = 0; m_trig = 0; m_rdv = 0; m_rlast = 0;
      end else if (arm && (m_state == 0 || m_state == 3)) begin
         m_state = 1; m_hist.delete(); m_trig = 0;
         m_postlen = (int'(post_count) > D - 1) ? D - 1 : int'(post_count);
      end else begin
         case (m_state)
            1: if (sample_en) begin
               model_store();
               if (model_fires()) begin
                  m_trig = 1;
                  if (m_postlen == 0) m_state = 3;
                  else begin m_state = 2; m_post = m_postlen; end
               end
            end
            2: if (sample_en) begin
               model_store();
               m_post--;
               if (m_post == 0) m_state = 3;
            end
            3: if (rd_start) begin
               m_state = 4; m_stream = m_hist; m_ridx = 0;
            end
            4: if (!m_rdv || rd_ready) begin
               if (m_ridx < m_stream.size()) begin
                  m_rdata = m_stream[m_ridx];
                  m_rlast = (m_ridx == m_stream.size() - 1);
                  m_rdv   = 1;
                  m_ridx++;
               end else begin
                  m_rdv = 0; m_rlast = 0; m_state = 3;
               end
            end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      check("state", RW'(state), RW'(m_state));
      check("fill", RW'(fill), RW'(m_hist.size()));
      check("triggered", RW'(triggered), RW'(m_trig));
      check("rd_valid", RW'(rd_valid), RW'(m_rdv));
      check("rd_last", RW'(rd_last), RW'(m_rlast));
      if (m_rdv) check("rd_data", rd_data, m_rdata);
   endtask

   task automatic quiet();
      rst = 0; arm = 0; abort = 0; sample_en = 0; ext_trig = 0;
      rd_start = 0; rd_ready = 0;
   endtask

   task automatic do_arm(input logic [1:0] mode, input logic [WW-1:0] tv, input logic [CW-1:0] pcnt);
      trig_mode = mode; trig_value = tv; post_count = pcnt;
      arm = 1; tick(); arm = 0;
   endtask

   // rd_ready follows pat[cycle % plen]; beats are captured as they transfer.
   task automatic readout(input logic [7:0] pat, input int plen);
      int cyc = 0;
      rd_got.delete(); rd_got_last.delete();
      rd_start = 1; tick(); rd_start = 0;
      while (state == 3'd4 && cyc < 200) begin
         rd_ready = pat[cyc % plen];
         if (rd_valid && rd_ready) begin
            rd_got.push_back(rd_data);
            rd_got_last.push_back(rd_last);
         end
         tick();
         cyc++;
      end
      rd_ready = 0;
      check("readout_bounded", RW'(cyc < 200), RW'(1));
   endtask

   initial begin
      quiet();
      rst = 1; trig_mode = 0; trig_value = '0; post_count = '0;
      pc = '0; exec_state = '0; rec_in = '0;
      tick();
      rst = 0;
      check("reset_rd_data", rd_data, '0);
      check("reset_state", RW'(state), RW'(0));

      // PC-match trigger with wrap: window is 0x34..0x43.
      do_arm(2'd1, 16'h0040, CW'(3));
      for (int i = 0; i < 32; i++) begin
         sample_en = 1; pc = WW'(16'h0030 + i); rec_in = RW'(pc);
         tick();
         if (i == 19) check("t1_done_after_0x43", RW'(state), RW'(3));
      end
      sample_en = 0;
      check("t1_fill", RW'(fill), RW'(16));
      readout(8'hFF, 8);
      check("t1_beats", RW'(rd_got.size()), RW'(16));
      for (int i = 0; i < rd_got.size(); i++) begin
         check("t1_data", rd_got[i], RW'(16'h0034 + i));
         check("t1_last", RW'(rd_got_last[i]), RW'(i == 15));
      end

      // Immediate trigger, no post samples.
      do_arm(2'd0, '0, '0);
      sample_en = 1; rec_in = RW'(8'hA5); tick(); sample_en = 0;
      check("t2_done", RW'(state), RW'(3));
      check("t2_fill", RW'(fill), RW'(1));
      readout(8'hFF, 8);
      check("t2_beats", RW'(rd_got.size()), RW'(1));
      if (rd_got.size() == 1) begin
         check("t2_data", rd_got[0], RW'(8'hA5));
         check("t2_last", RW'(rd_got_last[0]), RW'(1));
      end

      // Exec-state trigger on bit 7 with gapped samples.
      do_arm(2'd2, WW'(7), CW'(2));
      for (int i = 0; i < 8; i++) begin
         sample_en = (i % 2 == 0);
         exec_state = SW'(1) << ((i == 0) ? 7 : 3);
         rec_in = RW'(16'h0100 + i);
         tick();
         if (i == 1 || i == 3) check("t3_post_hold", RW'(state), RW'(2));
      end
      sample_en = 0;
      check("t3_fill", RW'(fill), RW'(3));
      check("t3_done", RW'(state), RW'(3));

      // Stalled readout, then replay.
      readout(8'b0001_1001, 5);
      check("t4_beats", RW'(rd_got.size()), RW'(3));
      for (int i = 0; i < rd_got.size(); i++) check("t4_data", rd_got[i], RW'(16'h0100 + 2 * i));
      check("t4_back_to_done", RW'(state), RW'(3));
      saved = rd_got;
      readout(8'hFF, 8);
      check("t4_replay_len", RW'(rd_got.size()), RW'(saved.size()));
      for (int i = 0; i < rd_got.size() && i < saved.size(); i++) check("t4_replay", rd_got[i], saved[i]);

      // Abort mid-POST, then abort together with arm.
      do_arm(2'd0, '0, CW'(5));
      sample_en = 1; rec_in = RW'(1); tick();
      rec_in = RW'(2); tick();
      check("t5_triggered", RW'(triggered), RW'(1));
      abort = 1; rec_in = RW'(3); tick(); abort = 0;
      check("t5_idle", RW'(state), RW'(0));
      check("t5_trig_clr", RW'(triggered), RW'(0));
      check("t5_fill_kept", RW'(fill), RW'(2));
      for (int i = 0; i < 3; i++) tick();
      sample_en = 0;
      check("t5_no_writes", RW'(fill), RW'(2));
      abort = 1; arm = 1; tick(); abort = 0; arm = 0;
      check("t5_abort_beats_arm", RW'(state), RW'(0));

      // Reset during readout.
      do_arm(2'd0, '0, CW'(1));
      sample_en = 1; rec_in = RW'(16'hBEEF); tick(); tick(); sample_en = 0;
      rd_start = 1; tick(); rd_start = 0;
      rd_ready = 0; tick();
      check("t6_valid_up", RW'(rd_valid), RW'(1));
      rst = 1; tick(); rst = 0;
      check("t6_state", RW'(state), RW'(0));
      check("t6_valid", RW'(rd_valid), RW'(0));
      check("t6_fill", RW'(fill), RW'(0));
      check("t6_data", rd_data, '0);

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         abort     = ($urandom_range(0, 99) == 0);
         arm       = ($urandom_range(0, 14) == 0);
         if ($urandom_range(0, 29) == 0) trig_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 29) == 0) trig_value = WW'($urandom_range(0, 15));
         post_count = CW'($urandom_range(0, 31));
         pc         = WW'($urandom_range(0, 15));
         exec_state = SW'(1) << $urandom_range(0, SW - 1);
         ext_trig   = ($urandom_range(0, 7) == 0);
         sample_en  = ($urandom_range(0, 9) < 7);
         rec_in     = {$urandom, $urandom};
         rd_start   = ($urandom_range(0, 3) == 0);
         rd_ready   = ($urandom_range(0, 9) < 6);
         tick();
      end
      quiet();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
Parametrised trace-capture successor to the combinational CPU debug packer. It records a per-cycle CPU debug record into a circular buffer while armed, and stops on a programmable trigger after a programmable number of post-trigger samples. A handshaked read port then streams the captured window out oldest-first. It sits beside the multi-cycle CPU, fed by the flattened debug record, the PC and the one-hot execution-state register.

Parameters:
WORD_WIDTH, 16, width of PC and trigger compare value
REC_WIDTH, 64, width of one trace record
DEPTH, 16, buffer entries; power of two, >=4
STATE_WIDTH, 10, width of one-hot exec state input
CW, $clog2(DEPTH)+1, count/post-count width (derived, localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
arm  in  1  pulse: clear buffer, start capture
abort  in  1  pulse: return to IDLE from any state
trig_mode  in  2  0=immediate, 1=PC match, 2=exec-state match, 3=external
trig_value  in  WORD_WIDTH  PC value (mode 1) or state bit index in low bits (mode 2)
post_count  in  CW  samples to store after the trigger sample; sampled on arm
sample_en  in  1  record valid this cycle
pc  in  WORD_WIDTH  current PC
exec_state  in  STATE_WIDTH  one-hot exec state
ext_trig  in  1  external trigger
rec_in  in  REC_WIDTH  trace record
rd_start  in  1  pulse: begin readout
rd_ready  in  1  consumer ready
rd_valid  out  1  rd_data valid
rd_data  out  REC_WIDTH  record, oldest first
rd_last  out  1  final record of window
state  out  3  0=IDLE,1=ARMED,2=POST,3=DONE,4=READOUT
fill  out  CW  stored entries, saturates at DEPTH
triggered  out  1  trigger seen since last arm

Behaviour:
- Reset: state=IDLE; wptr, fill, post counter=0; rd_valid, rd_last, triggered=0; rd_data=0.
- Priority per cycle: rst > abort > arm > everything else.
- Abort: next state IDLE. rd_valid/rd_last drop next cycle. Buffer contents and fill are kept; triggered is cleared.
- IDLE/DONE + arm: next state ARMED. wptr=0, fill=0, triggered=0. post_count latched and clamped to DEPTH-1. arm is ignored in ARMED/POST/READOUT.
- ARMED, sample_en: write rec_in at wptr; wptr+1 mod DEPTH; fill+1 saturating at DEPTH.
- Trigger is evaluated only on a sample_en cycle in ARMED:
  - mode0: always true.
  - mode1: pc==trig_value.
  - mode2: exec_state[trig_value[$clog2(STATE_WIDTH)-1:0]]; an index >= STATE_WIDTH never matches.
  - mode3: ext_trig.
- On a trigger, the triggering sample is stored and triggered=1 next cycle. If latched post_count==0, next state is DONE; otherwise next state is POST with the counter set to post_count.
- POST, sample_en: store the sample and decrement the counter. The store that takes the counter from 1 to 0 moves the state to DONE on the next cycle. Cycles without sample_en store nothing and leave the counter unchanged.
- Wrap: pre-trigger samples overwrite the oldest entries. The window always ends with the last post sample.
- DONE + rd_start: next state READOUT. rptr = (wptr - fill) mod DEPTH and the remaining count = fill. rd_start is ignored outside DONE.
- READOUT:
  - rd_data is registered. rd_valid rises exactly 1 cycle after entering READOUT.
  - Transfer occurs when rd_valid && rd_ready. rd_data, rd_valid and rd_last hold stable while rd_valid && !rd_ready.
  - After each transfer the next record is presented the following cycle, so back-to-back rd_ready gives one record per cycle.
  - rd_last=1 with the record where remaining==1.
  - After the last transfer: rd_valid=0 next cycle and state returns to DONE. The buffer is unchanged and can be re-read.
- sample_en outside ARMED/POST writes nothing.
- fill >= 1 whenever DONE is reached, because the trigger sample is always stored.

Test Plan:
- DEPTH=16, mode1, trig_value=0x0040, post_count=3, PC sequence 0x0030..0x004F on consecutive samples → DONE after sample 0x0043; fill=16; readout gives PCs 0x0034..0x0043 in order; rd_last on 0x0043.
- mode0, post_count=0, single sample rec=0xA5 → DONE 1 cycle after the sample; fill=1; readout gives one beat 0xA5 with rd_valid and rd_last both high.
- mode2, trig_value=7 (WRITE_BACK), post_count=2, sample_en gapped every other cycle → exactly 3 records stored from the trigger onward; the counter holds on gap cycles.
- Readout with rd_ready pattern 1,0,0,1,1 → rd_data unchanged across stall cycles; no record lost or duplicated; state returns to DONE; a second rd_start replays an identical stream.
- abort asserted mid-POST and on the same cycle as arm → state=IDLE next cycle; triggered=0; no further writes; arm ignored.
- rst asserted during READOUT with rd_valid=1 → next cycle: state=IDLE, rd_valid=0, fill=0, rd_data=0.
